// File: rtl/sh7604_pkg.sv
// Shared SH7604 definitions: multiplier op codes and the MAC sequencer state type.
package sh7604_pkg;

    localparam logic [3:0] MACOP_STS    = 4'b0000;
    localparam logic [3:0] MACOP_MULL   = 4'b0001;
    localparam logic [3:0] MACOP_DMULU  = 4'b0010;
    localparam logic [3:0] MACOP_DMULS  = 4'b0011;
    localparam logic [3:0] MACOP_LDS    = 4'b0100;
    localparam logic [3:0] MACOP_MULUW  = 4'b0110;
    localparam logic [3:0] MACOP_MULSW  = 4'b0111;
    localparam logic [3:0] MACOP_MACL   = 4'b1001;
    localparam logic [3:0] MACOP_MACW   = 4'b1011;
    localparam logic [3:0] MACOP_CLRMAC = 4'b1111;

    typedef enum logic [2:0] {
        MS_IDLE,
        MS_WAIT_IDLE,
        MS_FETCH_N,
        MS_FETCH_M,
        MS_ISSUE_1,
        MS_ISSUE_2,
        MS_STS_RD,
        MS_DONE
    } MacSeqState_t;

    function automatic logic is_mac_op(input logic [3:0] op);
        return (op == MACOP_MACL) || (op == MACOP_MACW);
    endfunction

    // Operand stride: MAC.W walks half-words, MAC.L walks long-words.
    function automatic logic [31:0] mac_inc(input logic [3:0] op);
        return (op == MACOP_MACW) ? 32'd2 : 32'd4;
    endfunction

endpackage

// File: rtl/sh7604_mac_seq.sv
// Sequencer between the SH7604 execute stage and the multiply/accumulate unit.
// Build option SH7604_MACSEQ_OVERLAP_EN: let MAC.x operand fetches overlap a busy multiplier.
module sh7604_mac_seq
    import sh7604_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        EN,
    input  logic        REQ,
    input  logic [3:0]  OP,
    input  logic [1:0]  SEL,
    input  logic        SAT,
    input  logic [31:0] RM,
    input  logic [31:0] RN,
    input  logic        SAME,
    output logic        ACK,
    output logic [31:0] RM_NEW,
    output logic [31:0] RN_NEW,
    output logic        RM_WB,
    output logic        RN_WB,
    output logic [31:0] STS_DATA,
    output logic [31:0] MEM_A,
    output logic        MEM_REQ,
    input  logic        MEM_RDY,
    input  logic [31:0] MEM_DI,
    output logic [1:0]  MAC_SEL,
    output logic [3:0]  MAC_OP,
    output logic        MAC_S,
    output logic        MAC_WE,
    output logic [31:0] MAC_DI,
    output logic [31:0] MAC_A,
    input  logic        MAC_BUSY,
    input  logic [31:0] MAC_DO
);

    MacSeqState_t state, state_nx;

    logic        en;
    logic [3:0]  op_q;
    logic [1:0]  sel_q;
    logic        sat_q;
    logic        same_q;
    logic [31:0] rm_q, rn_q;
    logic [31:0] d1_q, d2_q, a1_q, a2_q;
    logic [31:0] sts_q, rm_new_q, rn_new_q;
    logic [31:0] inc_in, fetch_m_addr;
    logic        mac_q;

    assign en           = CE_R & EN;
    assign inc_in       = mac_inc(OP);
    assign mac_q        = is_mac_op(op_q);
    assign fetch_m_addr = same_q ? (rn_q + mac_inc(op_q)) : rm_q;

    function automatic MacSeqState_t dispatch(input logic [3:0] op);
        case (op)
`ifdef SH7604_MACSEQ_OVERLAP_EN
            MACOP_MACL, MACOP_MACW:                 return MS_FETCH_N;
`else
            MACOP_MACL, MACOP_MACW:                 return MS_WAIT_IDLE;
`endif
            MACOP_MULL, MACOP_DMULU, MACOP_DMULS:   return MS_ISSUE_1;
            MACOP_MULUW, MACOP_MULSW,
            MACOP_LDS, MACOP_CLRMAC:                return MS_ISSUE_2;
            MACOP_STS:                              return MS_STS_RD;
            default:                                return MS_DONE;
        endcase
    endfunction

    // Control and visible result registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= MS_IDLE;
            op_q     <= '0;
            sel_q    <= '0;
            sat_q    <= 1'b0;
            same_q   <= 1'b0;
            sts_q    <= '0;
            rm_new_q <= '0;
            rn_new_q <= '0;
        end else if (en) begin
            state <= state_nx;
            if (state == MS_IDLE && REQ) begin
                op_q     <= OP;
                sel_q    <= SEL;
                sat_q    <= SAT;
                same_q   <= SAME;
                rm_new_q <= RM + inc_in;
                rn_new_q <= RN + (SAME ? {inc_in[30:0], 1'b0} : inc_in);
            end
            if (state == MS_STS_RD && !MAC_BUSY)
                sts_q <= MAC_DO;
        end
    end

    // Operand and fetch data registers
    always_ff @(posedge CLK) begin
        if (en) begin
            if (state == MS_IDLE && REQ) begin
                rm_q <= RM;
                rn_q <= RN;
            end
            if (state == MS_FETCH_N && MEM_RDY) begin
                d1_q <= MEM_DI;
                a1_q <= rn_q;
            end
            if (state == MS_FETCH_M && MEM_RDY) begin
                d2_q <= MEM_DI;
                a2_q <= fetch_m_addr;
            end
        end
    end

    always_comb begin
        state_nx = state;
        MEM_REQ  = 1'b0;
        MEM_A    = '0;
        MAC_SEL  = 2'b00;
        MAC_WE   = 1'b0;
        MAC_DI   = '0;
        MAC_A    = '0;
        ACK      = 1'b0;
        case (state)
            MS_IDLE: begin
                if (REQ)
                    state_nx = dispatch(OP);
            end
            MS_WAIT_IDLE: begin
                MAC_SEL = 2'b11;
                if (!MAC_BUSY)
                    state_nx = MS_FETCH_N;
            end
            MS_FETCH_N: begin
                MEM_REQ = 1'b1;
                MEM_A   = rn_q;
                if (MEM_RDY)
                    state_nx = MS_FETCH_M;
            end
            MS_FETCH_M: begin
                MEM_REQ = 1'b1;
                MEM_A   = fetch_m_addr;
                if (MEM_RDY)
                    state_nx = MS_ISSUE_1;
            end
            MS_ISSUE_1: begin
                if (mac_q) begin
                    MAC_SEL = 2'b10;
                    MAC_DI  = d1_q;
                    MAC_A   = a1_q;
                end else begin
                    MAC_SEL = 2'b01;
                    MAC_DI  = rm_q;
                end
                MAC_WE = !MAC_BUSY;
                if (!MAC_BUSY)
                    state_nx = MS_ISSUE_2;
            end
            MS_ISSUE_2: begin
                // Second write: the low-order half for MAC.x, the sole write for single-write ops
                case (op_q)
                    MACOP_MACL, MACOP_MACW: begin
                        MAC_SEL = 2'b01;
                        MAC_DI  = d2_q;
                        MAC_A   = a2_q;
                    end
                    MACOP_MULUW, MACOP_MULSW: begin
                        MAC_SEL = 2'b10;
                        MAC_DI  = {rn_q[15:0], rm_q[15:0]};
                    end
                    MACOP_LDS: begin
                        MAC_SEL = sel_q;
                        MAC_DI  = rm_q;
                    end
                    MACOP_CLRMAC: MAC_SEL = 2'b11;
                    default: begin
                        MAC_SEL = 2'b10;
                        MAC_DI  = rn_q;
                    end
                endcase
                MAC_WE = !MAC_BUSY;
                if (!MAC_BUSY)
                    state_nx = MS_DONE;
            end
            MS_STS_RD: begin
                MAC_SEL = sel_q;
                if (!MAC_BUSY)
                    state_nx = MS_DONE;
            end
            MS_DONE: begin
                ACK      = 1'b1;
                state_nx = MS_IDLE;
            end
            default: state_nx = MS_IDLE;
        endcase
    end

    assign MAC_OP   = (state != MS_IDLE) ? op_q  : 4'b0000;
    assign MAC_S    = (state != MS_IDLE) ? sat_q : 1'b0;
    assign RN_WB    = ACK && mac_q;
    assign RM_WB    = ACK && mac_q && !same_q;
    assign RM_NEW   = rm_new_q;
    assign RN_NEW   = rn_new_q;
    assign STS_DATA = sts_q;

endmodule

// File: doc/sh7604_mac_seq.md
# sh7604_mac_seq

Sequencer that drives the SH7604 multiply/accumulate unit on behalf of the CPU core. It accepts one MAC-class instruction at a time and performs the operand memory fetches for MAC.W/MAC.L (@Rm+, @Rn+). It issues the ordered operand writes to the multiplier, waiting while the multiplier is busy, and returns post-incremented register values or STS read data. It sits between the core's execute stage and the multiplier's CBUS-style port.

## Interface
Parameters:
- none; op encodings come from the shared package.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- CE_R  in  1  rising-phase clock enable; all state advances only when CE_R && EN.
- EN  in  1  global enable.
- REQ  in  1  instruction request; held by core until ACK.
- OP  in  4  multiplier op code (same encoding the multiplier uses; 4'b0000 = STS).
- SEL  in  2  MACL/MACH target for LDS/STS.
- SAT  in  1  SR.S bit.
- RM, RN  in  32  register values (addresses for MAC.x, operands otherwise).
- SAME  in  1  Rm and Rn are the same register.
- ACK  out  1  one-enabled-cycle completion pulse.
- RM_NEW, RN_NEW  out  32  post-increment values.
- RM_WB, RN_WB  out  1  writeback strobes, coincident with ACK.
- STS_DATA  out  32  captured MACH/MACL.
- MEM_A  out  32  fetch address.
- MEM_REQ  out  1  fetch request.
- MEM_RDY  in  1  fetch complete; MEM_DI valid.
- MEM_DI  in  32  fetch data.
- MAC_SEL  out  2  multiplier select.
- MAC_OP  out  4  multiplier op.
- MAC_S  out  1  multiplier saturation bit.
- MAC_WE  out  1  multiplier write.
- MAC_DI  out  32  multiplier data.
- MAC_A  out  32  multiplier address; word fetch address, so bit 1 selects the half-word.
- MAC_BUSY  in  1  multiplier busy; valid only while MAC_SEL != 0.
- MAC_DO  in  32  multiplier read data.

## Operation
States:
- IDLE. With REQ && CE_R && EN, latch OP/SEL/SAT/RM/RN/SAME, then dispatch by OP:
  - MAC.L (1001) / MAC.W (1011) -> FETCH_N.
  - MUL.L/DMULU/DMULS (0001/0010/0011) -> ISSUE_1.
  - MULU.W/MULS.W (0110/0111), LDS (0100), CLRMAC (1111) -> ISSUE_2.
  - STS (0000) -> STS_RD.
  - Any other code -> DONE with no side effects.
- FETCH_N: MEM_A = RN, MEM_REQ = 1 until MEM_RDY; capture D1 and A1 -> FETCH_M.
- FETCH_M: MEM_A = SAME ? RN+inc : RM, where inc = 2 (W) / 4 (L); capture D2 and A2 -> ISSUE_1.
- ISSUE_1: MAC_SEL held at first target with MAC_WE = 0 while MAC_BUSY. When clear, MAC_WE = 1 for exactly one enabled cycle -> ISSUE_2.
  - MAC.x: SEL = 10, DI = D1, A = A1.
  - MUL/DMUL: SEL = 01, DI = RM.
- ISSUE_2: same busy handshake, then one write -> DONE.
  - MAC.x: SEL = 01, DI = D2, A = A2.
  - MUL/DMUL: SEL = 10, DI = RN.
  - MULx.W: SEL = 10, DI = {RN[15:0], RM[15:0]}.
  - LDS: SEL = latched SEL, DI = RM.
  - CLRMAC: SEL = 11.
- STS_RD: MAC_SEL = latched SEL, MAC_WE = 0. When !MAC_BUSY, STS_DATA <= MAC_DO -> DONE.
- DONE: ACK = 1 -> IDLE.

Other rules:
- MAC_OP = latched OP and MAC_S = latched SAT in all non-IDLE states.
- Writeback (MAC.x only):
  - SAME = 0: RN_NEW = RN+inc, RM_NEW = RM+inc, both strobes set.
  - SAME = 1: RN_NEW = RN+2·inc, RN_WB only.
  - Address arithmetic wraps modulo 2^32.

## Timing
- Reset values: every output 0, state IDLE, STS_DATA 0.
- RST_N is asynchronous. Asserting it mid-fetch drops MEM_REQ immediately and the in-flight MEM_RDY is ignored. Asserting it mid-issue aborts with no ACK.
- Latency with zero-wait memory and idle multiplier, counted in enabled cycles from REQ acceptance to the ACK cycle:
  - LDS/CLRMAC/MULx.W: 2.
  - MUL/DMUL: 3.
  - MAC.x: 5.
  - STS: 2.
- Each MAC_BUSY cycle adds one cycle in ISSUE_x/STS_RD; each MEM_RDY-low cycle adds one in FETCH_x.
- REQ seen in a non-IDLE state is ignored.
- CE_R low or EN low freezes all state. MAC_WE and ACK remain asserted until consumed by an enabled cycle.

## Configuration
- SH7604_MACSEQ_OVERLAP_EN defined: FETCH_N/FETCH_M proceed while the multiplier is still busy from the previous op; only ISSUE_x waits.
- Undefined: IDLE→FETCH_N is preceded by a WAIT_IDLE state holding MAC_SEL = 11, MAC_WE = 0 until !MAC_BUSY, so no fetch overlaps a running multiply.

## Structure
- SH7604_PKG gets:
  - MAC op-code constants: MACOP_STS, MACOP_MULL, MACOP_DMULU, MACOP_DMULS, MACOP_LDS, MACOP_MULUW, MACOP_MULSW, MACOP_MACL, MACOP_MACW, MACOP_CLRMAC.
  - The state enum typedef MacSeqState_t.
- Single module; no sub-module is natural.

## Test plan
- LDS, OP = 0100, SEL = 10, RM = 0x12345678, idle multiplier -> one MAC_WE with MAC_SEL = 10, MAC_DI = 0x12345678; ACK 2 cycles after acceptance.
- DMULS, RM = 0xFFFFFFFE, RN = 3, MAC_BUSY high 3 cycles during ISSUE_1:
  - Write 1 (SEL = 01, DI = 0xFFFFFFFE) delayed 3 cycles, then write 2 (SEL = 10, DI = 3).
  - ACK at cycle 6.
- MAC.W, RN = 0x1000, RM = 0x2002, SAME = 0:
  - Fetches at 0x1000 then 0x2002; MAC_A mirrors them.
  - RN_NEW = 0x1002, RM_NEW = 0x2004, both WB.
- MAC.L, SAME = 1, RN = 0xFFFFFFFC:
  - Fetches at 0xFFFFFFFC and 0x00000000.
  - RN_NEW = 0x00000004, RM_WB = 0.
- STS with MAC_BUSY high 2 cycles, MAC_DO = 0xCAFEF00D -> no MAC_WE; STS_DATA = 0xCAFEF00D at ACK.
- RST_N pulsed during FETCH_M with MEM_RDY pending -> MEM_REQ drops at once; no MAC_WE, no ACK, state IDLE.
